// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Decodes the FD and DX instructions to detect load-use hazards and
// mult/div operations, sequences the multi-cycle mult/div unit with a
// timeout, and produces the per-latch enable/flush controls plus a
// saturating stall-cycle counter for performance debug.
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_flush,
  output logic             xm_en,
  output logic             xm_flush,
  output logic             mw_en,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // The busy counter only has to reach MD_TIMEOUT-1, where it forces a release.
  localparam int BCW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [BCW-1:0] BUSY_LAST = BCW'(MD_TIMEOUT - 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t      state, state_nxt;
  logic [BCW-1:0] busy_cnt, busy_cnt_nxt;
  logic           md_err_set;
  logic           md_release;
  logic           md_stall;

  // Instruction field decode
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       fd_uses_rt, fd_uses_rd;
  logic       dx_is_md, load_use;
  logic       unused_ir_bits;

  assign fd_op    = fd_ir[31:27];
  assign fd_rd    = fd_ir[26:22];
  assign fd_rs    = fd_ir[21:17];
  assign fd_rt    = fd_ir[16:12];
  assign dx_op    = dx_ir[31:27];
  assign dx_rd    = dx_ir[26:22];
  assign dx_aluop = dx_ir[6:2];

  // Fields the controller never looks at are collapsed here so they stay visible as intentional.
  assign unused_ir_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  // rt is a source only for R-type; stores, compare-branches and jr read rd.
  assign fd_uses_rt = (fd_op == OP_RTYPE);
  assign fd_uses_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                      (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign dx_is_md = (dx_op == OP_RTYPE) &&
                    ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

  // A load into r0 never produces a value, so it cannot create a hazard.
  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((fd_rs == dx_rd) ||
                     (fd_uses_rt && (fd_rt == dx_rd)) ||
                     (fd_uses_rd && (fd_rd == dx_rd)));

  assign mw_en = 1'b1;

  // Mult/div FSM state, busy counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy_cnt <= '0;
      md_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy_cnt <= busy_cnt_nxt;
      md_err   <= md_err | md_err_set;
    end
  end

  // Next-state logic and prioritised stall/flush controls
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    md_err_set   = 1'b0;
    md_release   = 1'b0;
    md_start     = 1'b0;
    md_busy      = 1'b0;
    md_stall     = 1'b0;
    pc_en        = 1'b1;
    fd_en        = 1'b1;
    dx_en        = 1'b1;
    xm_en        = 1'b1;
    fd_flush     = 1'b0;
    dx_flush     = 1'b0;
    xm_flush     = 1'b0;

    case (state)
      IDLE: begin
        if (dx_is_md) begin
          state_nxt    = BUSY;
          busy_cnt_nxt = '0;
          md_start     = 1'b1;
        end
      end
      BUSY: begin
        md_busy = 1'b1;
        if (md_ready || (busy_cnt == BUSY_LAST)) begin
          md_release = 1'b1;
          state_nxt  = IDLE;
          md_err_set = !md_ready;
        end else begin
          busy_cnt_nxt = busy_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // The start cycle stalls too, so the mult/div stays in DX until it is released.
    md_stall = md_start || (md_busy && !md_release);

    if (md_stall) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_en    = 1'b0;
      xm_flush = 1'b1;
    end else if (branch_taken) begin
      fd_flush = 1'b1;
      dx_flush = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      dx_flush = 1'b1;
    end

    // While reset is held the pipeline must see a plain advance, not a decoded stall.
    if (reset) begin
      md_start = 1'b0;
      md_busy  = 1'b0;
      pc_en    = 1'b1;
      fd_en    = 1'b1;
      dx_en    = 1'b1;
      xm_en    = 1'b1;
      fd_flush = 1'b0;
      dx_flush = 1'b0;
      xm_flush = 1'b0;
    end
  end

  // Saturating count of clock edges where the PC was held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized instruction streams compared every cycle against a
// rule-level reference model. A second instance with a 4-bit counter
// covers stall counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fd_ir = '0;
  logic [31:0] dx_ir = '0;
  logic        branch_taken = 1'b0;
  logic        md_ready = 1'b0;

  logic pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, xm_flush, mw_en;
  logic md_start, md_busy, md_err;
  logic [15:0] stall_cnt;

  logic b_pc_en, b_fd_en, b_fd_flush, b_dx_en, b_dx_flush, b_xm_en, b_xm_flush, b_mw_en;
  logic b_md_start, b_md_busy, b_md_err;
  logic [3:0] b_stall_cnt;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit m_busy = 0;
  int m_cycles = 0;
  bit m_err = 0;
  int m_stalls = 0;

  // Free-running clock
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .dx_en(dx_en),
    .dx_flush(dx_flush), .xm_en(xm_en), .xm_flush(xm_flush), .mw_en(mw_en),
    .md_start(md_start), .md_busy(md_busy), .md_err(md_err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_en(b_pc_en), .fd_en(b_fd_en), .fd_flush(b_fd_flush), .dx_en(b_dx_en),
    .dx_flush(b_dx_flush), .xm_en(b_xm_en), .xm_flush(b_xm_flush), .mw_en(b_mw_en),
    .md_start(b_md_start), .md_busy(b_md_busy), .md_err(b_md_err), .stall_cnt(b_stall_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input int rd, input int rs, input int rt, input logic [4:0] aluop);
    return {5'b00000, 5'(rd), 5'(rs), 5'(rt), 5'(0), aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_type(input logic [4:0] op, input int rd, input int rs);
    return {op, 5'(rd), 5'(rs), 17'($urandom_range(0, 131071))};
  endfunction

  function automatic logic [31:0] rand_ir();
    int rd = $urandom_range(0, 3);
    int rs = $urandom_range(0, 3);
    int rt = $urandom_range(0, 3);
    logic [4:0] alu;
    case ($urandom_range(0, 7))
      0, 1: begin
        if ($urandom_range(0, 5) == 0) alu = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
        else alu = 5'($urandom_range(0, 31));
        return r_type(rd, rs, rt, alu);
      end
      2: return i_type(5'b01000, rd, rs);
      3: return i_type(5'b00111, rd, rs);
      4: return i_type(5'b00010, rd, rs);
      5: return i_type(5'b00110, rd, rs);
      6: return i_type(5'b00100, rd, rs);
      default: return i_type(5'($urandom_range(1, 31)), rd, rs);
    endcase
  endfunction

  // Registers the FD instruction reads, straight from the ISA operand rules
  function automatic bit model_load_use(input logic [31:0] fd, input logic [31:0] dx);
    int srcs[$];
    int op = int'(fd[31:27]);
    int target = int'(dx[26:22]);
    if (dx[31:27] != 5'b01000 || target == 0) return 0;
    srcs.push_back(int'(fd[21:17]));
    if (op == 0) srcs.push_back(int'(fd[16:12]));
    if (op == 7 || op == 2 || op == 6 || op == 4) srcs.push_back(int'(fd[26:22]));
    foreach (srcs[i]) if (srcs[i] == target) return 1;
    return 0;
  endfunction

  // Compare process: evaluate the rules mid-cycle, check, then advance the model
  always @(negedge clk) begin
    bit dx_md, rel, hold, lu;
    bit e_pc, e_fd, e_fdf, e_dx, e_dxf, e_xm, e_xmf, e_start;
    int sat_a, sat_b;
    if (reset) begin
      m_busy = 0; m_cycles = 0; m_err = 0; m_stalls = 0;
      e_pc = 1; e_fd = 1; e_fdf = 0; e_dx = 1; e_dxf = 0; e_xm = 1; e_xmf = 0; e_start = 0;
      rel = 0; dx_md = 0;
    end else begin
      dx_md = (dx_ir[31:27] == 5'd0) && (dx_ir[6:2] == 5'd6 || dx_ir[6:2] == 5'd7);
      lu = model_load_use(fd_ir, dx_ir);
      rel = m_busy && (md_ready || m_cycles == TMO - 1);
      hold = (m_busy && !rel) || (!m_busy && dx_md);
      e_start = !m_busy && dx_md;
      e_pc = 1; e_fd = 1; e_fdf = 0; e_dx = 1; e_dxf = 0; e_xm = 1; e_xmf = 0;
      if (hold) begin e_pc = 0; e_fd = 0; e_dx = 0; e_xmf = 1; end
      else if (branch_taken) begin e_fdf = 1; e_dxf = 1; end
      else if (lu) begin e_pc = 0; e_fd = 0; e_dxf = 1; end
    end
    sat_a = (m_stalls > 65535) ? 65535 : m_stalls;
    sat_b = (m_stalls > 15) ? 15 : m_stalls;
    check_output("ctrl_a",
      {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, xm_flush, mw_en, md_start, md_busy, md_err},
      {e_pc, e_fd, e_fdf, e_dx, e_dxf, e_xm, e_xmf, 1'b1, e_start, (m_busy && !reset), m_err});
    check_output("ctrl_b",
      {b_pc_en, b_fd_en, b_fd_flush, b_dx_en, b_dx_flush, b_xm_en, b_xm_flush, b_mw_en, b_md_start, b_md_busy, b_md_err},
      {e_pc, e_fd, e_fdf, e_dx, e_dxf, e_xm, e_xmf, 1'b1, e_start, (m_busy && !reset), m_err});
    check_output("stall_cnt_a", 32'(stall_cnt), 32'(sat_a));
    check_output("stall_cnt_b", 32'(b_stall_cnt), 32'(sat_b));
    if (!reset) begin
      if (!e_pc) m_stalls++;
      if (m_busy) begin
        if (rel) begin m_busy = 0; if (!md_ready) m_err = 1; end
        else m_cycles++;
      end else if (dx_md) begin
        m_busy = 1; m_cycles = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] fd, input logic [31:0] dx, input logic br, input logic rdy);
    tick();
    fd_ir = fd;
    dx_ir = dx;
    branch_taken = br;
    md_ready = rdy;
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    logic [31:0] nop_i, lw_r5, add_use, lw_r0, add_r0, mul_i, div_i;
    nop_i   = 32'h0;
    lw_r5   = i_type(5'b01000, 5, 0);
    add_use = r_type(1, 5, 2, 5'd0);
    lw_r0   = i_type(5'b01000, 0, 3);
    add_r0  = r_type(1, 0, 2, 5'd0);
    mul_i   = r_type(3, 1, 2, 5'b00110);
    div_i   = r_type(4, 1, 2, 5'b00111);

    tick();
    #1;
    check_output("reset_pc_en", 32'(pc_en), 32'd1);
    check_output("reset_md_busy", 32'(md_busy), 32'd0);
    check_output("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b0;

    // Load-use stalls one cycle; a load into r0 does not
    apply_stimulus(add_use, lw_r5, 1'b0, 1'b0);
    #1;
    check_output("lu_pc_en", 32'(pc_en), 32'd0);
    check_output("lu_fd_en", 32'(fd_en), 32'd0);
    check_output("lu_dx_flush", 32'(dx_flush), 32'd1);
    apply_stimulus(add_use, nop_i, 1'b0, 1'b0);
    #1;
    check_output("lu_after_pc_en", 32'(pc_en), 32'd1);
    check_output("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    apply_stimulus(add_r0, lw_r0, 1'b0, 1'b0);
    #1;
    check_output("lw_r0_pc_en", 32'(pc_en), 32'd1);

    // Branch overrides load-use
    apply_stimulus(add_use, lw_r5, 1'b1, 1'b0);
    #1;
    check_output("br_pc_en", 32'(pc_en), 32'd1);
    check_output("br_fd_flush", 32'(fd_flush), 32'd1);
    check_output("br_dx_flush", 32'(dx_flush), 32'd1);
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    #1;
    check_output("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Multiply released by md_ready on the 17th BUSY cycle
    apply_stimulus(nop_i, mul_i, 1'b0, 1'b0);
    #1;
    check_output("mul_start", 32'(md_start), 32'd1);
    check_output("mul_start_pc_en", 32'(pc_en), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      apply_stimulus(nop_i, mul_i, 1'b0, (i == 17));
      #1;
      check_output("mul_busy", 32'(md_busy), 32'd1);
      check_output("mul_no_restart", 32'(md_start), 32'd0);
      if (i < 17) check_output("mul_xm_flush", 32'(xm_flush), 32'd1);
      else begin
        check_output("mul_release_pc_en", 32'(pc_en), 32'd1);
        check_output("mul_release_xm_flush", 32'(xm_flush), 32'd0);
      end
    end
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    #1;
    check_output("mul_done_busy", 32'(md_busy), 32'd0);
    check_output("mul_stall_cnt", 32'(stall_cnt), 32'd18);

    // Divide with no md_ready times out after 64 BUSY cycles
    apply_stimulus(nop_i, div_i, 1'b0, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      apply_stimulus(nop_i, div_i, 1'b0, 1'b0);
      #1;
      if (i == TMO - 1) check_output("tmo_pre_pc_en", 32'(pc_en), 32'd0);
      if (i == TMO) begin
        check_output("tmo_release_pc_en", 32'(pc_en), 32'd1);
        check_output("tmo_err_before", 32'(md_err), 32'd0);
      end
    end
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    #1;
    check_output("tmo_err", 32'(md_err), 32'd1);
    check_output("tmo_busy", 32'(md_busy), 32'd0);
    apply_stimulus(nop_i, div_i, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) apply_stimulus(nop_i, div_i, 1'b0, (i == 3));
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    #1;
    check_output("err_sticky", 32'(md_err), 32'd1);

    // Asynchronous reset in the 5th BUSY cycle
    apply_stimulus(nop_i, mul_i, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) apply_stimulus(nop_i, mul_i, 1'b0, 1'b0);
    #1;
    check_output("pre_reset_busy", 32'(md_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_output("async_busy", 32'(md_busy), 32'd0);
    check_output("async_pc_en", 32'(pc_en), 32'd1);
    check_output("async_dx_en", 32'(dx_en), 32'd1);
    check_output("async_xm_flush", 32'(xm_flush), 32'd0);
    check_output("async_stall_cnt", 32'(stall_cnt), 32'd0);
    check_output("async_err", 32'(md_err), 32'd0);
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    reset = 1'b0;

    // Twenty stalled edges saturate the 4-bit counter
    apply_stimulus(add_use, lw_r5, 1'b0, 1'b0);
    repeat (19) apply_stimulus(add_use, lw_r5, 1'b0, 1'b0);
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    #1;
    check_output("sat_cnt_b", 32'(b_stall_cnt), 32'd15);
    check_output("sat_cnt_a", 32'(stall_cnt), 32'd20);

    // Randomized streams with occasional resets
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(rand_ir(), rand_ir(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      reset = ($urandom_range(0, 299) == 0);
    end
    apply_stimulus(nop_i, nop_i, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
